thread_issue_scheduler: RTL and testbench
=========================================

# thread_issue_scheduler

Per-cycle fine-grained thread scheduler for the multithreaded 5-stage pipeline. Each cycle it selects one eligible hardware thread round-robin and issues that thread's index and PC to fetch. It also maintains one PC per thread, enforces a minimum re-issue gap per thread, and parks threads that are waiting on an outstanding load/store until the memory stage wakes them. It sits at the head of the pipeline. It feeds fetch and receives block, wake and redirect events from downstream stages.

## Interface
- THREAD_INDEX_BITS, 3, width of a thread index; NUM_THREADS = 2**THREAD_INDEX_BITS
- PC_WIDTH, 16, per-thread PC width
- ISSUE_GAP, 3, minimum cycles between two issues of the same thread (≥1)
- RESET_PC, 0, PC value of every thread after reset

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- in_thread_enable  in  NUM_THREADS  per-thread run enable; bit i = 0 makes thread i ineligible
- in_stall  in  1  global pipeline stall; freezes issue
- in_block_valid  in  1  decode saw a load/store; block the thread in in_block_thread
- in_block_thread  in  THREAD_INDEX_BITS  thread to block
- in_wake_valid  in  1  memory op completed; unblock the thread in in_wake_thread
- in_wake_thread  in  THREAD_INDEX_BITS  thread to wake
- in_redirect_valid  in  1  overwrite one thread's PC (branch/jump)
- in_redirect_thread  in  THREAD_INDEX_BITS  thread to redirect
- in_redirect_pc  in  PC_WIDTH  new PC
- out_issue_valid  out  1  registered; a thread was issued this cycle
- out_issue_thread  out  THREAD_INDEX_BITS  registered issued thread index
- out_issue_pc  out  PC_WIDTH  registered PC of issued thread

## Operation
- State:
  - pc[NUM_THREADS]
  - blocked[NUM_THREADS]
  - gap_cnt[NUM_THREADS], each wide enough for ISSUE_GAP-1
  - last_grant, THREAD_INDEX_BITS wide
- Eligible(i) is true only when all of the following hold:
  - in_thread_enable[i] is 1
  - blocked[i] is 0
  - gap_cnt[i] is 0
  - it is not the case that in_block_valid is high and in_block_thread == i
- Arbitration:
  - Search starts at last_grant+1, modulo NUM_THREADS, wrapping; the first eligible thread wins.
  - If no thread is eligible, nothing is issued.
- Issue (in_stall = 0 and a winner w exists), at the edge:
  - out_issue_valid <= 1, out_issue_thread <= w, out_issue_pc <= pc[w]
  - pc[w] <= pc[w]+1, wrapping modulo 2**PC_WIDTH
  - last_grant <= w
  - gap_cnt[w] <= ISSUE_GAP-1
- No issue (stalled, or no eligible thread):
  - out_issue_valid <= 0
  - out_issue_thread and out_issue_pc hold their values
  - last_grant holds
- gap_cnt:
  - Every nonzero gap_cnt decrements by 1 each cycle in_stall = 0, except a counter being reloaded that cycle.
  - While in_stall = 1, all counters hold.
- Block/wake:
  - in_block_valid sets blocked[t]; in_wake_valid clears blocked[t].
  - Both are processed regardless of in_stall.
  - Block and wake for the same thread in the same cycle: block wins.
  - Wake of an unblocked thread is a no-op.
- Redirect:
  - Sets pc[t] <= in_redirect_pc and is processed regardless of in_stall.
  - If the same thread issues that cycle, the redirect value wins over the increment.
  - That issue carries the old PC; squashing it is downstream's job.
- Disabling a thread (enable bit 0) does not clear its blocked or pc state.

## Timing
- Issue latency is 1 cycle: inputs sampled at edge N appear on out_* after edge N.
- Effects of block, wake and redirect:
  - A block masks the thread in the same cycle.
  - A wake makes the thread eligible for the next cycle's decision.
  - A redirected PC is issued no earlier than the next issue of that thread.
- With a single eligible thread and no stall, it issues every ISSUE_GAP cycles; ISSUE_GAP = 1 means every cycle.
- Reset values:
  - out_issue_valid = 0, out_issue_thread = 0, out_issue_pc = 0
  - every pc = RESET_PC
  - blocked = 0, gap_cnt = 0
  - last_grant = NUM_THREADS-1, so thread 0 is granted first
- Reset mid-operation overrides all concurrent block, wake and redirect inputs.
- With all threads enabled and none blocked, the steady-state issue order is 0,1,…,NUM_THREADS-1,0,…

## Test plan
- Reset, all 8 threads enabled, ISSUE_GAP=3 → out_issue_thread 0,1,2,…,7,0 on consecutive cycles; second visit of thread 0 has pc=1.
- Only thread 5 enabled, ISSUE_GAP=3 → valid on every third cycle, thread 5, pc 0,1,2,…; valid=0 in between.
- Threads 0–2 enabled, block thread 1 in the cycle it would be selected → sequence 0,2,0,2; wake thread 1 → thread 1 reappears in its round-robin slot with its pc unchanged.
- Same-cycle block and wake of thread 3 → thread 3 stays blocked; wake alone on the next cycle → thread 3 eligible the cycle after.
- Redirect thread 2 to 0x0100 while thread 2 issues at pc 0x0004 → that issue carries 0x0004; next thread-2 issue carries 0x0100, the following one 0x0101; pc 0xFFFF increments to 0x0000.
- in_stall high for 4 cycles mid-sequence → out_issue_valid=0 throughout, last_grant and gap counters frozen; order resumes where it stopped. Reset asserted mid-sequence → thread 0, pc 0 first after release.

Source files
------------

// File: rtl/thread_issue_scheduler.sv
// thread_issue_scheduler
//
// Fine-grained round-robin thread scheduler at the head of the pipeline.
// Each cycle it picks one eligible hardware thread, starting the search just
// after the previously granted thread. It then issues that thread's index and
// PC to fetch on the following cycle. It keeps one PC per thread and enforces
// a minimum re-issue gap per thread. Threads waiting on a load/store stay
// parked until the memory stage wakes them.
//
// Ports:
//   clk                 clock, all state updates on posedge
//   reset               synchronous, active-high reset
//   in_thread_enable    per-thread run enable
//   in_stall            global pipeline stall, freezes issue and gap counters
//   in_block_valid      block thread in_block_thread (load/store seen)
//   in_block_thread     thread to block
//   in_wake_valid       unblock thread in_wake_thread (memory op completed)
//   in_wake_thread      thread to wake
//   in_redirect_valid   overwrite PC of in_redirect_thread
//   in_redirect_thread  thread to redirect
//   in_redirect_pc      new PC
//   out_issue_valid     registered, a thread was issued
//   out_issue_thread    registered issued thread index
//   out_issue_pc        registered PC of the issued thread

module thread_issue_scheduler #(
  parameter int THREAD_INDEX_BITS = 3,
  parameter int PC_WIDTH          = 16,
  parameter int ISSUE_GAP         = 3,
  parameter int RESET_PC          = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [(2**THREAD_INDEX_BITS)-1:0] in_thread_enable,
  input  logic                              in_stall,
  input  logic                              in_block_valid,
  input  logic [THREAD_INDEX_BITS-1:0]      in_block_thread,
  input  logic                              in_wake_valid,
  input  logic [THREAD_INDEX_BITS-1:0]      in_wake_thread,
  input  logic                              in_redirect_valid,
  input  logic [THREAD_INDEX_BITS-1:0]      in_redirect_thread,
  input  logic [PC_WIDTH-1:0]               in_redirect_pc,
  output logic                              out_issue_valid,
  output logic [THREAD_INDEX_BITS-1:0]      out_issue_thread,
  output logic [PC_WIDTH-1:0]               out_issue_pc
);

  localparam int NUM_THREADS = 2**THREAD_INDEX_BITS;
  // Counter only has to hold ISSUE_GAP-1; keep at least one bit for ISSUE_GAP=1.
  localparam int GAP_WIDTH = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GAP_WIDTH-1:0] GAP_RELOAD = GAP_WIDTH'(ISSUE_GAP - 1);

  logic [PC_WIDTH-1:0]          pc      [NUM_THREADS];
  logic [GAP_WIDTH-1:0]         gap_cnt [NUM_THREADS];
  logic [NUM_THREADS-1:0]       blocked;
  logic [THREAD_INDEX_BITS-1:0] last_grant;

  logic [NUM_THREADS-1:0]       eligible;
  logic [THREAD_INDEX_BITS-1:0] winner;
  logic [THREAD_INDEX_BITS-1:0] cand;
  logic                         found;
  logic                         issue;

  // A block arriving this cycle masks its thread immediately, before the
  // blocked flag is even registered.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      eligible[i] = in_thread_enable[i] && !blocked[i] && (gap_cnt[i] == '0) &&
                    !(in_block_valid && (in_block_thread == THREAD_INDEX_BITS'(i)));
    end
  end

  // Round-robin search from last_grant+1; index arithmetic wraps naturally
  // because NUM_THREADS is a power of two.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      cand = last_grant + THREAD_INDEX_BITS'(k);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign issue = found && !in_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_issue_valid  <= 1'b0;
      out_issue_thread <= '0;
      out_issue_pc     <= '0;
      last_grant       <= THREAD_INDEX_BITS'(NUM_THREADS - 1);
      blocked          <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc[i]      <= PC_WIDTH'(RESET_PC);
        gap_cnt[i] <= '0;
      end
    end else begin
      out_issue_valid <= issue;
      if (issue) begin
        out_issue_thread <= winner;
        out_issue_pc     <= pc[winner];
        last_grant       <= winner;
      end

      for (int i = 0; i < NUM_THREADS; i++) begin
        // Block has priority over a same-cycle wake of the same thread.
        if (in_block_valid && (in_block_thread == THREAD_INDEX_BITS'(i))) begin
          blocked[i] <= 1'b1;
        end else if (in_wake_valid && (in_wake_thread == THREAD_INDEX_BITS'(i))) begin
          blocked[i] <= 1'b0;
        end

        // Redirect beats the post-issue increment; the issue in flight still
        // carries the old PC and is squashed downstream.
        if (in_redirect_valid && (in_redirect_thread == THREAD_INDEX_BITS'(i))) begin
          pc[i] <= in_redirect_pc;
        end else if (issue && (winner == THREAD_INDEX_BITS'(i))) begin
          pc[i] <= pc[i] + PC_WIDTH'(1);
        end

        if (issue && (winner == THREAD_INDEX_BITS'(i))) begin
          gap_cnt[i] <= GAP_RELOAD;
        end else if (!in_stall && (gap_cnt[i] != '0)) begin
          gap_cnt[i] <= gap_cnt[i] - GAP_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// Directed testbench for thread_issue_scheduler with default parameters
// (8 threads, 16-bit PC, ISSUE_GAP = 3, RESET_PC = 0).

module tb_thread_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_thread_enable = 8'h00;
  logic        in_stall = 1'b0;
  logic        in_block_valid = 1'b0;
  logic [2:0]  in_block_thread = 3'd0;
  logic        in_wake_valid = 1'b0;
  logic [2:0]  in_wake_thread = 3'd0;
  logic        in_redirect_valid = 1'b0;
  logic [2:0]  in_redirect_thread = 3'd0;
  logic [15:0] in_redirect_pc = 16'h0000;
  logic        out_issue_valid;
  logic [2:0]  out_issue_thread;
  logic [15:0] out_issue_pc;

  int checks = 0;
  int errors = 0;

  thread_issue_scheduler dut (
    .clk                (clk),
    .reset              (reset),
    .in_thread_enable   (in_thread_enable),
    .in_stall           (in_stall),
    .in_block_valid     (in_block_valid),
    .in_block_thread    (in_block_thread),
    .in_wake_valid      (in_wake_valid),
    .in_wake_thread     (in_wake_thread),
    .in_redirect_valid  (in_redirect_valid),
    .in_redirect_thread (in_redirect_thread),
    .in_redirect_pc     (in_redirect_pc),
    .out_issue_valid    (out_issue_valid),
    .out_issue_thread   (out_issue_thread),
    .out_issue_pc       (out_issue_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input string tag, input int t, input int pcv);
    chk({tag, "_valid"},  32'(out_issue_valid),  32'd1);
    chk({tag, "_thread"}, 32'(out_issue_thread), 32'(t));
    chk({tag, "_pc"},     32'(out_issue_pc),     32'(pcv));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_issue_valid), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    tick();
    chk({tag, "_rst_valid"},  32'(out_issue_valid),  32'd0);
    chk({tag, "_rst_thread"}, 32'(out_issue_thread), 32'd0);
    chk({tag, "_rst_pc"},     32'(out_issue_pc),     32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // All threads enabled: 0..7 then 0 again with pc 1.
    in_thread_enable = 8'hFF;
    do_reset("rr");
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_issue($sformatf("rr_t%0d", i), i, 0);
    end
    tick();
    expect_issue("rr_wrap", 0, 1);

    // Only thread 5: issues every third cycle, holds outputs in between.
    in_thread_enable = 8'h20;
    do_reset("solo");
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e % 3 == 0) begin
        expect_issue($sformatf("solo_e%0d", e + 1), 5, e / 3);
      end else begin
        expect_idle($sformatf("solo_e%0d", e + 1));
        chk($sformatf("solo_hold_thr_e%0d", e + 1), 32'(out_issue_thread), 32'd5);
      end
    end

    // Threads 0-2, block thread 1 in its slot, wake it later.
    in_thread_enable = 8'h07;
    do_reset("blk");
    tick();
    expect_issue("blk_e1", 0, 0);
    in_block_valid = 1'b1; in_block_thread = 3'd1;
    tick();
    expect_issue("blk_e2", 2, 0);
    in_block_valid = 1'b0;
    tick();
    expect_idle("blk_e3");
    tick();
    expect_issue("blk_e4", 0, 1);
    tick();
    expect_issue("blk_e5", 2, 1);
    tick();
    expect_idle("blk_e6");
    in_wake_valid = 1'b1; in_wake_thread = 3'd1;
    tick();
    expect_issue("blk_e7", 0, 2);
    in_wake_valid = 1'b0;
    tick();
    expect_issue("blk_e8", 1, 0);
    tick();
    expect_issue("blk_e9", 2, 2);

    // Same-cycle block and wake of thread 3: block wins.
    in_thread_enable = 8'h08;
    do_reset("bw");
    in_block_valid = 1'b1; in_block_thread = 3'd3;
    in_wake_valid  = 1'b1; in_wake_thread  = 3'd3;
    tick();
    expect_idle("bw_e1");
    in_block_valid = 1'b0;
    tick();
    expect_idle("bw_e2");
    in_wake_valid = 1'b0;
    tick();
    expect_issue("bw_e3", 3, 0);

    // Redirect thread 2 while it issues pc 4, then PC wrap at 0xFFFF.
    in_thread_enable = 8'h04;
    do_reset("rd");
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 10) expect_issue("rd_e10", 2, 3);
    end
    in_redirect_valid = 1'b1; in_redirect_thread = 3'd2; in_redirect_pc = 16'h0100;
    tick();
    expect_issue("rd_e13", 2, 4);
    in_redirect_valid = 1'b0;
    tick(); tick(); tick();
    expect_issue("rd_e16", 2, 16'h0100);
    tick(); tick(); tick();
    expect_issue("rd_e19", 2, 16'h0101);
    in_redirect_valid = 1'b1; in_redirect_pc = 16'hFFFF;
    tick();
    expect_idle("rd_e20");
    in_redirect_valid = 1'b0;
    tick(); tick();
    expect_issue("rd_e22", 2, 16'hFFFF);
    tick(); tick(); tick();
    expect_issue("rd_e25", 2, 16'h0000);

    // Stall for 4 cycles right after thread 0 issues: gap counters frozen.
    in_thread_enable = 8'h03;
    do_reset("st");
    tick();
    expect_issue("st_e1", 0, 0);
    in_stall = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      tick();
      expect_idle($sformatf("st_e%0d", e));
      chk($sformatf("st_hold_thr_e%0d", e), 32'(out_issue_thread), 32'd0);
    end
    in_stall = 1'b0;
    tick();
    expect_issue("st_e6", 1, 0);
    tick();
    expect_idle("st_e7");
    tick();
    expect_issue("st_e8", 0, 1);
    tick();
    expect_issue("st_e9", 1, 1);

    // Reset mid-operation with concurrent block and redirect on thread 0.
    in_block_valid = 1'b1; in_block_thread = 3'd0;
    in_redirect_valid = 1'b1; in_redirect_thread = 3'd0; in_redirect_pc = 16'h0055;
    do_reset("mr");
    in_block_valid = 1'b0;
    in_redirect_valid = 1'b0;
    tick();
    expect_issue("mr_e1", 0, 0);
    tick();
    expect_issue("mr_e2", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
